// File: rtl/sb_cfg_pkg.sv
// Shared state encoding, size defaults and helpers for the switch-block
// configuration loader.
package sb_cfg_pkg;

    localparam int NUM_MEMS_DEF     = 18;
    localparam int BITS_PER_MEM_DEF = 2;
    localparam int DEC_W_DEF        = 5;
    localparam int BYTE_W_DEF       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic int total_bits(input int num_mems, input int bits_per_mem);
        return num_mems * bits_per_mem;
    endfunction

endpackage

// File: rtl/sb_cfg_bank_loader_if.sv
// Byte stream carrying the configuration bitstream into the loader.
interface sb_cfg_bank_loader_if
    import sb_cfg_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF
);

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/sb_cfg_byte_shifter.sv
// Holds the byte being written out; bit 0 of the register is the bit
// currently on data_in, bit 1 is the one that follows it.
module sb_cfg_byte_shifter
    import sb_cfg_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_next_bit,
    output logic              o_empty
);

    logic [BYTE_W-1:0] r_sh;
    logic [2:0]        r_left;

    // Rotating rather than zero-filling keeps every bit observable; only
    // r_left decides how many bits are still meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_left <= '0;
        end else if (i_load) begin
            r_sh   <= i_byte;
            r_left <= 3'(BYTE_W - 1);
        end else if (i_shift) begin
            r_sh   <= {r_sh[0], r_sh[BYTE_W-1:1]};
            r_left <= (r_left != 3'd0) ? r_left - 3'd1 : 3'd0;
        end
    end

    assign o_next_bit = r_sh[1];
    assign o_empty    = (r_left == 3'd0);

endmodule

// File: rtl/sb_cfg_bank_loader.sv
// Streams configuration bytes into the switch block's mux memories, one
// SETUP/STROBE bit write at a time, and pulses done after the last bit.
module sb_cfg_bank_loader
    import sb_cfg_pkg::*;
#(
    parameter int NUM_MEMS     = NUM_MEMS_DEF,
    parameter int BITS_PER_MEM = BITS_PER_MEM_DEF,
    parameter int DEC_W        = DEC_W_DEF,
    parameter int BYTE_W       = BYTE_W_DEF
) (
    input  logic                 prog_clk,
    input  logic                 prog_rst_n,
    input  logic                 start,
    input  logic                 abort,
    sb_cfg_bank_loader_if.slave  s_in,
    output logic                 enable,
    output logic [DEC_W:0]       address,
    output logic                 data_in,
    output logic                 busy,
    output logic                 done
);

    localparam int        TOTAL  = total_bits(NUM_MEMS, BITS_PER_MEM);
    localparam logic [5:0] LAST_K = 6'(TOTAL - 1);

    state_e         r_state;
    state_e         w_nxt;
    logic [5:0]     r_k;
    logic [DEC_W:0] r_addr;
    logic           r_data;
    logic           r_enable;
    logic           r_in_ready;
    logic           r_busy;
    logic           r_done;
    logic           w_last;
    logic           w_load;
    logic           w_shift;
    logic           w_next_bit;
    logic           w_empty;

    // address[0] picks the bit within a memory; address[1..DEC_W] carry
    // the memory index with address[1] as its most significant bit.
    function automatic logic [DEC_W:0] form_addr(input logic [5:0] k);
        logic [DEC_W:0] a;
        logic [5:0]     q;
        q    = k >> 1;
        a[0] = k[0];
        for (int i = 1; i <= DEC_W; i++) a[i] = q[DEC_W-i];
        return a;
    endfunction

    assign w_last  = (r_k == LAST_K);
    assign w_load  = (r_state == ST_LOAD) && (w_nxt == ST_SETUP);
    assign w_shift = (r_state == ST_STROBE) && !abort;

    always_comb begin
        w_nxt = r_state;
        if (abort) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start) w_nxt = ST_LOAD;
                ST_LOAD:   if (s_in.in_valid) w_nxt = ST_SETUP;
                ST_SETUP:  w_nxt = ST_STROBE;
                ST_STROBE: begin
                    if (w_last)       w_nxt = ST_DONE;
                    else if (w_empty) w_nxt = ST_LOAD;
                    else              w_nxt = ST_SETUP;
                end
                ST_DONE:   w_nxt = ST_IDLE;
                default:   w_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are flopped from the next state so the strobe is glitch-free.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_addr     <= '0;
            r_data     <= 1'b0;
            r_enable   <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_enable   <= (w_nxt == ST_STROBE);
            r_in_ready <= (w_nxt == ST_LOAD);
            r_busy     <= (w_nxt != ST_IDLE);
            r_done     <= (w_nxt == ST_DONE);
            if ((r_state == ST_IDLE) && (w_nxt == ST_LOAD)) begin
                r_k <= '0;
            end else if (w_shift) begin
                r_k <= r_k + 6'd1;
            end
            if (w_nxt == ST_SETUP) begin
                if (r_state == ST_LOAD) begin
                    r_addr <= form_addr(r_k);
                    r_data <= s_in.in_data[0];
                end else begin
                    r_addr <= form_addr(r_k + 6'd1);
                    r_data <= w_next_bit;
                end
            end
        end
    end

    sb_cfg_byte_shifter #(
        .BYTE_W (BYTE_W)
    ) u_shifter (
        .clk        (prog_clk),
        .rst_n      (prog_rst_n),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_byte     (s_in.in_data),
        .o_next_bit (w_next_bit),
        .o_empty    (w_empty)
    );

    assign s_in.in_ready = r_in_ready;
    assign enable        = r_enable;
    assign address       = r_addr;
    assign data_in       = r_data;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: doc/sb_cfg_bank_loader.md
# sb_cfg_bank_loader

Configuration loader sitting directly upstream of a memory-bank-configured switch block: it accepts the block's configuration bitstream as bytes over a valid/ready stream. It drives the switch block's `enable`, `address[0:5]` and `data_in` ports with one two-cycle write per configuration bit. The block's 18 two-bit mux memories are configured bit by bit: `address[1:5]` selects a memory through the block's 5-to-18 decoder, and `address[0]` selects the bit within that memory. The loader signals completion so a chip-level configuration sequencer can move on to the next tile.

## Interface
Parameters:
- `NUM_MEMS`, 18, mux memories in the target block (decoder outputs).
- `BITS_PER_MEM`, 2, configuration bits per memory; fixed, occupies `address[0]`.
- `DEC_W`, 5, decoder address width (`address[1:5]`).
- `BYTE_W`, 8, input stream width.

Ports (one clock; reset is asynchronous and active-low):
- `prog_clk` input 1: configuration clock.
- `prog_rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a load; honoured only in IDLE.
- `abort` input 1: synchronous cancel; returns to IDLE on the next edge.
- `in_data` input BYTE_W: bitstream byte, LSB first.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `enable` output 1: to the switch block `enable`; write strobe.
- `address` output 1+DEC_W: to the switch block `address[0:5]`.
- `data_in` output 1: to the switch block `data_in`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last bit has been written.

## Operation
- Total bits `TOTAL = NUM_MEMS*BITS_PER_MEM` = 36; bytes consumed `ceil(TOTAL/BYTE_W)` = 5.
- Bit index k runs 0..TOTAL-1.
  - `address[1:5]` = k/2, with `address[1]` as the MSB.
  - `address[0]` = k%2.
  - `data_in` = current bit.
- Byte bits are consumed LSB first. In the final byte, bits beyond TOTAL (bits 4..7) are discarded, but the byte is still accepted.

State machine:
- IDLE: `start` -> LOAD. Bit counter and byte counter are cleared.
- LOAD: `in_ready` = 1. On `in_valid && in_ready`, capture the byte into the shift register and go to SETUP. Otherwise remain in LOAD indefinitely (no timeout).
- SETUP: drive `address` and `data_in` for bit k with `enable` = 0 -> STROBE.
- STROBE: `enable` = 1, with `address` and `data_in` unchanged from SETUP. Then:
  - if k = TOTAL-1 -> DONE;
  - else if all 8 bits of the byte are used -> LOAD;
  - else -> SETUP.
  - k increments in all cases.
- DONE: `done` = 1 for one cycle -> IDLE.

Boundary rules:
- `abort` has priority over all transitions. In STROBE, the strobe already in progress completes that cycle, and `enable` is 0 from the next cycle on.
- `start` while `busy` is ignored. A `start` coincident with `abort` in IDLE is ignored.
- `in_ready` is 0 in every state other than LOAD.
- `address` and `data_in` hold their last values in IDLE and DONE.

## Timing
- Reset values:
  - `enable` = 0, `address` = 0, `data_in` = 0;
  - `in_ready` = 0, `busy` = 0, `done` = 0;
  - state = IDLE, counters = 0.
- All outputs are registered; none depend combinationally on inputs.
- `start` sampled at edge 0 -> LOAD and `in_ready` = 1 from edge 1.
- Byte accepted at edge n -> SETUP at n+1 -> first `enable` high at n+2.
- Each bit costs exactly 2 cycles; within a byte, writes occur on every second cycle.
- With `in_valid` held high, the full load takes 1 + 5 (LOAD) + 72 (bit writes) + 1 (DONE) = 79 cycles from `start` to the `done` pulse.
- Address/data setup to `enable` is one full cycle, and hold is zero cycles (they change only in the SETUP following a strobe). This satisfies the switch block's bank-write requirement.

## Structure
- Shared package `sb_cfg_pkg`:
  - state enum (IDLE, LOAD, SETUP, STROBE, DONE);
  - `NUM_MEMS`, `BITS_PER_MEM`, `DEC_W`, `BYTE_W` defaults;
  - a `TOTAL_BITS` constant function.
- Sub-module `sb_cfg_byte_shifter`:
  - BYTE_W shift register with load/shift controls;
  - 3-bit "bits left" count;
  - `empty` flag.
- The top level holds the FSM, bit counter (6 bits) and address formation.

## Test plan
- Reset mid-STROBE (assert `prog_rst_n` = 0 asynchronously) -> `enable`, `busy` and `in_ready` are 0 immediately; the next `start` restarts from k = 0.
- `start`, `in_valid` held high, bytes 0xA5,0x3C,0xFF,0x00,0x09 -> 36 `enable` pulses with the following `data_in` bits:
  - k0..7: 1,0,1,0,0,1,0,1;
  - k32..35: 1,0,0,1;
  - address at k = 35 is {`address[0]`=1, `address[1:5]`=17};
  - `done` pulses at cycle 79.
- Backpressure: `in_valid` dropped for 10 cycles before the 3rd byte -> the loader waits in LOAD with `enable` = 0, and the data sequence is unchanged; `done` pulses at cycle 89.
- `abort` asserted during the 2nd byte -> `busy` = 0 on the next cycle, no further `enable` pulses, and `done` never pulses.
- `start` pulsed while busy -> ignored; the sequence and the `done` timing are identical to the uninterrupted run.
